// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver.
//
// Recovers frames of the form: start bit (0), DATA_WIDTH data bits LSB
// first, an optional parity bit, and one stop bit (1). Each serial bit lasts
// PRESCALE clock cycles. The line is resynchronised through two flops, and
// every decision is made on the synchronised copy rx_s.
//
// Parameters:
//   PRESCALE    clock cycles per serial bit (even, >= 4)
//   DATA_WIDTH  data bits per frame
//
// Ports:
//   CLK            clock
//   RST            asynchronous active-low reset
//   RX_IN          serial line, asynchronous to CLK, idle high
//   Parity_Enable  1 = frame carries a parity bit (latched at start detect)
//   Parity_Type    0 = even, 1 = odd (latched at start detect)
//   P_DATA         last good received word
//   Data_Valid     one-cycle pulse when P_DATA is updated
//   Parity_Error   one-cycle pulse on parity mismatch
//   Stop_Error     one-cycle pulse when the stop bit is sampled 0
//   Busy           high from start detection until return to IDLE
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit is the 2-of-3 majority
//   of samples at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, decided at
//   PRESCALE/2+1. When undefined, one sample is taken at PRESCALE/2.

module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int SAMPLE_POS = PRESCALE / 2 + 1;
`else
  localparam int SAMPLE_POS = PRESCALE / 2;
`endif

  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(SAMPLE_POS);
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                  sync1_q, sync2_q;
  logic                  rx_s;
  logic                  sample_bit;
  logic                  at_sample, at_wrap;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  busy_q, busy_d;

  // Two-flop synchronizer; reset to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The two early samples are held here; the third is rx_s itself at the
  // decision point, so the vote is ready without an extra cycle.
  logic [1:0] vote_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vote_q <= 2'b11;
    end else begin
      if (edge_cnt_q == CNT_W'(SAMPLE_POS - 2)) vote_q[0] <= rx_s;
      if (edge_cnt_q == CNT_W'(SAMPLE_POS - 1)) vote_q[1] <= rx_s;
    end
  end

  assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  assign at_sample = (edge_cnt_q == SAMPLE_PT);
  assign at_wrap   = (edge_cnt_q == EDGE_LAST);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    pdata_d    = pdata_q;
    busy_d     = busy_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    // The bit-period counter free-runs in every state that times bits.
    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d    = S_START;
          busy_d     = 1'b1;
          par_en_d   = Parity_Enable;
          par_type_d = Parity_Type;
          par_err_d  = 1'b0;
        end
      end

      S_START: begin
        if (at_sample && sample_bit) begin
          state_d    = S_IDLE;
          edge_cnt_d = '0;
          busy_d     = 1'b0;
        end else if (at_wrap) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (at_sample) begin
          shift_d = {sample_bit, shift_q[DATA_WIDTH-1:1]};
        end
        if (at_wrap) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (at_sample) begin
          par_err_d = sample_bit ^ (^shift_q) ^ par_type_q;
        end
        if (at_wrap) begin
          state_d = S_STOP;
        end
      end

      // Leaving at the sample point (half a bit early) leaves time to catch
      // a start bit that follows the stop bit with no idle gap.
      S_STOP: begin
        if (at_sample) begin
          edge_cnt_d = '0;
          if (sample_bit) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (par_err_q) begin
              pe_d = 1'b1;
            end else begin
              pdata_d = shift_q;
              dv_d    = 1'b1;
            end
          end else begin
            state_d = S_WAIT_HIGH;
            se_d    = 1'b1;
            pe_d    = par_err_q;
          end
        end
      end

      // A held-low line (break) must rise before another start is accepted.
      S_WAIT_HIGH: begin
        edge_cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      busy_q     <= busy_d;
    end
  end

  assign P_DATA       = pdata_q;
  assign Data_Valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_Error   = se_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (PRESCALE=8, DATA_WIDTH=8).
// Frames are driven bit by bit on RX_IN; a negedge monitor logs every output
// pulse, and a frame-level model decides which pulses each frame must give.

module tb_uart_rx;

  localparam int PRESCALE   = 8;
  localparam int DATA_WIDTH = 8;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_DELAY = 1;
`else
  localparam int VOTE_DELAY = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       Parity_Enable = 1'b0;
  logic       Parity_Type = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;
  logic       Busy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  longint     cycleCnt = 0;
  int         dvTotal = 0;
  int         peTotal = 0;
  int         seTotal = 0;
  int         ruleTotal = 0;
  logic [7:0] dvLog [0:511];
  longint     dvCyc [0:511];
  logic       dvPrev = 1'b0;
  logic       pePrev = 1'b0;
  logic       sePrev = 1'b0;

  logic [7:0] modelPData = 8'h00;
  logic       busyMid;

  uart_rx #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Parity_Enable(Parity_Enable),
    .Parity_Type  (Parity_Type),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error),
    .Busy         (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  // Pulse log: every pulse is counted; pulses longer than one cycle or a
  // Data_Valid coinciding with Stop_Error are counted as rule breaks.
  always @(negedge CLK) begin
    dvPrev <= Data_Valid;
    pePrev <= Parity_Error;
    sePrev <= Stop_Error;
    if (Data_Valid) begin
      dvLog[dvTotal] <= P_DATA;
      dvCyc[dvTotal] <= cycleCnt;
      dvTotal        <= dvTotal + 1;
    end
    if (Parity_Error) peTotal <= peTotal + 1;
    if (Stop_Error)   seTotal <= seTotal + 1;
    if ((Data_Valid && dvPrev) || (Parity_Error && pePrev) ||
        (Stop_Error && sePrev) || (Data_Valid && Stop_Error))
      ruleTotal <= ruleTotal + 1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic sendBit(input logic b);
    RX_IN = b;
    idle(PRESCALE);
  endtask

  // Parity config is scrambled after the start bit; the frame must still be
  // decoded with the values present when the start bit arrived.
  task automatic applyStimulus(input logic [7:0] d, input bit pen, input bit ptype,
                               input bit pbit, input bit stopb);
    Parity_Enable = pen;
    Parity_Type   = ptype;
    sendBit(1'b0);
    busyMid = Busy;
    Parity_Enable = 1'($urandom);
    Parity_Type   = 1'($urandom);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    if (pen) sendBit(pbit);
    sendBit(stopb);
  endtask

  function automatic bit goodParity(input logic [7:0] d, input bit ptype);
    return bit'($countones(d) % 2) ^ ptype;
  endfunction

  task automatic runFrame(input string tag, input logic [7:0] d, input bit pen,
                          input bit ptype, input bit corrupt, input bit stopb,
                          input int hold);
    int  dv0, pe0, se0, r0;
    bit  mismatch;
    int  expDv, expPe, expSe;
    dv0 = dvTotal;
    pe0 = peTotal;
    se0 = seTotal;
    r0  = ruleTotal;
    applyStimulus(d, pen, ptype, goodParity(d, ptype) ^ corrupt, stopb);
    if (!stopb) begin
      idle(hold);
      checkOutput({tag, ".busyWaitHigh"}, 32'(Busy), 32'd1);
    end
    RX_IN = 1'b1;
    idle(2 * PRESCALE + 4);

    mismatch = pen && corrupt;
    expDv = (stopb && !mismatch) ? 1 : 0;
    expPe = mismatch ? 1 : 0;
    expSe = stopb ? 0 : 1;
    if (expDv == 1) modelPData = d;

    checkOutput({tag, ".dvCount"}, 32'(dvTotal - dv0), 32'(expDv));
    checkOutput({tag, ".peCount"}, 32'(peTotal - pe0), 32'(expPe));
    checkOutput({tag, ".seCount"}, 32'(seTotal - se0), 32'(expSe));
    checkOutput({tag, ".pulseRules"}, 32'(ruleTotal - r0), 32'd0);
    checkOutput({tag, ".pData"}, 32'(P_DATA), 32'(modelPData));
    checkOutput({tag, ".busyIdle"}, 32'(Busy), 32'd0);
    if (expDv == 1 && dvTotal > dv0)
      checkOutput({tag, ".dvData"}, 32'(dvLog[dv0]), 32'(d));
  endtask

  initial begin
    int     idx, dv0, pe0, se0;
    longint driveCycle;
    int     latency;

    $display("[TB] uart_rx bench start, PRESCALE=%0d", PRESCALE);

    // Reset state.
    idle(3);
    checkOutput("reset.pData", 32'(P_DATA), 32'd0);
    checkOutput("reset.dv", 32'(Data_Valid), 32'd0);
    checkOutput("reset.pe", 32'(Parity_Error), 32'd0);
    checkOutput("reset.se", 32'(Stop_Error), 32'd0);
    checkOutput("reset.busy", 32'(Busy), 32'd0);
    RST = 1'b1;
    idle(4);

    // 0xA5, no parity, with latency and mid-frame Busy.
    // Latency from driving RX_IN low: two synchronizer edges, one edge where
    // the FSM reads rx_s=0, then the frame latency.
    idx = dvTotal;
    driveCycle = cycleCnt;
    runFrame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("a5.busyMid", 32'(busyMid), 32'd1);
    latency = (1 + 8) * PRESCALE + PRESCALE / 2 + 1 + VOTE_DELAY;
    if (dvTotal > idx)
      checkOutput("a5.latency", 32'(dvCyc[idx] - driveCycle), 32'(3 + latency));

    // Even parity, good then bad parity bit.
    runFrame("par3cGood", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    runFrame("par3cBad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0);

    // Stop bit 0 followed by a 40-cycle break.
    runFrame("stop55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 40);

    // 3-cycle low glitch on an idle line.
    dv0 = dvTotal; pe0 = peTotal; se0 = seTotal;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(2);
    checkOutput("glitch.busyStart", 32'(Busy), 32'd1);
    idle(3 * PRESCALE);
    checkOutput("glitch.busyIdle", 32'(Busy), 32'd0);
    checkOutput("glitch.pulses", 32'((dvTotal - dv0) + (peTotal - pe0) + (seTotal - se0)), 32'd0);

    // 1-cycle low spike.
    dv0 = dvTotal; pe0 = peTotal; se0 = seTotal;
    RX_IN = 1'b0;
    idle(1);
    RX_IN = 1'b1;
    idle(3 * PRESCALE);
    checkOutput("spike.busyIdle", 32'(Busy), 32'd0);
    checkOutput("spike.pulses", 32'((dvTotal - dv0) + (peTotal - pe0) + (seTotal - se0)), 32'd0);
    checkOutput("spike.pData", 32'(P_DATA), 32'(modelPData));

    // Back-to-back frames, no idle gap.
    idx = dvTotal;
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    RX_IN = 1'b1;
    idle(2 * PRESCALE + 4);
    modelPData = 8'hFF;
    checkOutput("b2b.dvCount", 32'(dvTotal - idx), 32'd2);
    if (dvTotal >= idx + 2) begin
      checkOutput("b2b.first", 32'(dvLog[idx]), 32'h01);
      checkOutput("b2b.second", 32'(dvLog[idx + 1]), 32'hFF);
    end
    checkOutput("b2b.pData", 32'(P_DATA), 32'(modelPData));

    // Reset during the DATA state.
    dv0 = dvTotal; pe0 = peTotal; se0 = seTotal;
    Parity_Enable = 1'b0;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    RST = 1'b0;
    #2;
    checkOutput("midReset.pData", 32'(P_DATA), 32'd0);
    checkOutput("midReset.busy", 32'(Busy), 32'd0);
    checkOutput("midReset.flags", 32'({Data_Valid, Parity_Error, Stop_Error}), 32'd0);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    idle(3);
    RST = 1'b1;
    idle(2 * PRESCALE);
    modelPData = 8'h00;
    checkOutput("midReset.pulses", 32'((dvTotal - dv0) + (peTotal - pe0) + (seTotal - se0)), 32'd0);
    checkOutput("midReset.pDataAfter", 32'(P_DATA), 32'd0);
    runFrame("after7e", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      runFrame($sformatf("rand%0d", n), 8'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
               int'($urandom_range(0, 30)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
